// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter granting one of four requesters access to a shared memory port.
// Grants are held until done, withdrawal of the request, or a wait-counter timeout.
module mem_port_arbiter #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] req,
   input  logic       done,
   output logic [3:0] gnt,
   output logic [1:0] sel,
   output logic       busy,
   output logic       timeout_err
);

   localparam int unsigned NUM_REQ = 4;
   localparam int unsigned IDX_W   = 2;
   localparam int unsigned CNT_W   = 8;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t             state_q;
   state_t             state_d;
   logic [NUM_REQ-1:0] gnt_d;
   logic [IDX_W-1:0]   sel_d;
   logic               busy_d;
   logic               timeout_err_d;
   logic [IDX_W-1:0]   last_q;
   logic [IDX_W-1:0]   last_d;
   logic [CNT_W-1:0]   cnt_q;
   logic [CNT_W-1:0]   cnt_d;

   logic               rr_found;
   logic [IDX_W-1:0]   rr_win;
   logic [IDX_W-1:0]   rr_idx;

   // Round-robin search starting one past the last winner, wrapping modulo four.
   always_comb begin
      rr_found = 1'b0;
      rr_win   = last_q;
      rr_idx   = last_q;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         rr_idx = last_q + IDX_W'(k);
         if (!rr_found && req[rr_idx]) begin
            rr_found = 1'b1;
            rr_win   = rr_idx;
         end
      end
   end

   // Next-state and registered-output logic; sel deliberately holds through IDLE.
   always_comb begin
      state_d       = state_q;
      gnt_d         = gnt;
      sel_d         = sel;
      last_d        = last_q;
      cnt_d         = cnt_q;
      timeout_err_d = 1'b0;

      case (state_q)
         IDLE: begin
            gnt_d = '0;
            cnt_d = '0;
            if (rr_found) begin
               state_d = GRANT;
               gnt_d   = NUM_REQ'(1) << rr_win;
               sel_d   = rr_win;
               last_d  = rr_win;
            end
         end
         GRANT: begin
            if (done || !req[sel]) begin
               // done has priority over both withdrawal and timeout
               state_d = IDLE;
               gnt_d   = '0;
               cnt_d   = '0;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               state_d       = IDLE;
               gnt_d         = '0;
               cnt_d         = '0;
               timeout_err_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            gnt_d   = '0;
            cnt_d   = '0;
         end
      endcase

      busy_d = (state_d == GRANT);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         gnt         <= '0;
         sel         <= '0;
         busy        <= 1'b0;
         timeout_err <= 1'b0;
         last_q      <= IDX_W'(NUM_REQ - 1);
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         gnt         <= gnt_d;
         sel         <= sel_d;
         busy        <= busy_d;
         timeout_err <= timeout_err_d;
         last_q      <= last_d;
         cnt_q       <= cnt_d;
      end
   end

endmodule
